// File: rtl/axi2mem_pkg.sv
// Shared encodings and helpers for the axi2mem read-channel controller.
package axi2mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } rd_state_e;

  // Reserved burst type, or a WRAP whose beat count is not 2, 4, 8 or 16.
  function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi2mem_id_fifo.sv
// Small ID/user/err FIFO tracking read bursts that are issued but not yet retired on R.
module axi2mem_id_fifo
  import axi2mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic                  pop_valid_o,
  input  logic                  pop_ready_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_push;
  logic                  w_pop;

  assign full_o       = (r_count == CNT_W'(DEPTH));
  assign empty_o      = (r_count == '0);
  assign pop_valid_o  = !empty_o;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push_ready_o = !full_o || pop_ready_i;
  assign w_push       = push_valid_i && push_ready_o;
  assign w_pop        = pop_valid_o && pop_ready_i;
  assign pop_data_o   = r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; r_count alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/axi2mem_rd_ctrl.sv
// AXI4 read-channel controller: splits AR bursts into per-port 32-bit memory beats and
// forwards returned memory data onto R, tagging it with the ID of the oldest open burst.
module axi2mem_rd_ctrl
  import axi2mem_pkg::*;
#(
  parameter  int unsigned AXI_ADDR_WIDTH = 32,
  parameter  int unsigned AXI_DATA_WIDTH = 64,
  parameter  int unsigned AXI_ID_WIDTH   = 3,
  parameter  int unsigned AXI_USER_WIDTH = 6,
  parameter  int unsigned PER_ID_WIDTH   = 6,
  parameter  int unsigned OUTSTANDING    = 4,
  localparam int unsigned NB_PORTS       = AXI_DATA_WIDTH / 32,
  localparam int unsigned BEAT_BYTES     = AXI_DATA_WIDTH / 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                ar_valid_i,
  output logic                                ar_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]           ar_addr_i,
  input  logic [7:0]                          ar_len_i,
  input  logic [2:0]                          ar_size_i,
  input  logic [1:0]                          ar_burst_i,
  input  logic [AXI_ID_WIDTH-1:0]             ar_id_i,
  input  logic [AXI_USER_WIDTH-1:0]           ar_user_i,
  output logic                                r_valid_o,
  input  logic                                r_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]           r_data_o,
  output logic [1:0]                          r_resp_o,
  output logic                                r_last_o,
  output logic [AXI_ID_WIDTH-1:0]             r_id_o,
  output logic [AXI_USER_WIDTH-1:0]           r_user_o,
  output logic [NB_PORTS-1:0]                 trans_req_o,
  input  logic [NB_PORTS-1:0]                 trans_gnt_i,
  output logic [NB_PORTS-1:0][31:0]           trans_add_o,
  output logic [NB_PORTS-1:0][PER_ID_WIDTH-1:0] trans_id_o,
  output logic [NB_PORTS-1:0]                 trans_last_o,
  input  logic [AXI_DATA_WIDTH-1:0]           data_dat_i,
  input  logic                                data_valid_i,
  output logic                                data_ready_o,
  input  logic                                data_last_i
);

  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int unsigned FIFO_W     = AXI_ID_WIDTH + AXI_USER_WIDTH + 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_MASK = AXI_ADDR_WIDTH'(BEAT_BYTES - 1);

  rd_state_e                 r_state;
  rd_state_e                 w_state_next;
  logic [AXI_ADDR_WIDTH-1:0] r_beat_addr;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_next;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_incr;
  logic [AXI_ADDR_WIDTH-1:0] w_wrap_mask;
  logic [7:0]                r_len;
  logic [7:0]                r_count;
  logic [1:0]                r_burst;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic                      r_ar_en;

  logic                      w_err;
  logic                      w_ar_hs;
  logic                      w_beat_hs;
  logic                      w_last_beat;
  logic                      w_unused;

  logic                      w_fifo_push_ready;
  logic                      w_fifo_pop_ready;
  logic                      w_fifo_pop_valid;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [FIFO_W-1:0]         w_fifo_pop_data;
  logic [AXI_ID_WIDTH-1:0]   w_head_id;
  logic [AXI_USER_WIDTH-1:0] w_head_user;
  logic                      w_head_err;

  // Every beat is full width, so the requested size carries no information here.
  assign w_unused = ^{ar_size_i, w_fifo_pop_valid};

  assign w_err       = burst_err(ar_burst_i, ar_len_i);
  // r_ar_en keeps AR closed for the whole reset and the first cycle after it.
  assign ar_ready_o  = r_ar_en && (r_state == S_IDLE) && !w_fifo_full;
  assign w_ar_hs     = ar_valid_i && ar_ready_o && w_fifo_push_ready;
  assign w_beat_hs   = (r_state == S_BURST) && (&trans_gnt_i);
  assign w_last_beat = (r_count == r_len);

  // WRAP container is (len+1) beats, naturally aligned; only bits inside it advance.
  assign w_addr_incr = r_beat_addr + AXI_ADDR_WIDTH'(BEAT_BYTES);
  assign w_wrap_mask = ((AXI_ADDR_WIDTH'(r_len) + AXI_ADDR_WIDTH'(1)) << BEAT_SHIFT)
                       - AXI_ADDR_WIDTH'(1);

  always_comb begin
    w_addr_next = r_beat_addr;
    case (r_burst)
      BURST_INCR: w_addr_next = w_addr_incr;
      BURST_WRAP: w_addr_next = (r_beat_addr & ~w_wrap_mask) | (w_addr_incr & w_wrap_mask);
      default:    w_addr_next = r_beat_addr;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    trans_req_o  = '0;
    trans_last_o = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_ar_hs) w_state_next = S_BURST;
      end
      S_BURST: begin
        trans_req_o  = '1;
        trans_last_o = {NB_PORTS{w_last_beat}};
        if (w_beat_hs && w_last_beat) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ar_en     <= 1'b0;
      r_beat_addr <= '0;
      r_len       <= '0;
      r_count     <= '0;
      r_burst     <= BURST_INCR;
      r_id        <= '0;
    end else begin
      r_ar_en <= 1'b1;
      if (w_ar_hs) begin
        r_beat_addr <= ar_addr_i & ~BEAT_MASK;
        r_len       <= ar_len_i;
        r_count     <= '0;
        // Illegal bursts still move real beats, as a plain incrementing burst.
        r_burst     <= w_err ? BURST_INCR : ar_burst_i;
        r_id        <= ar_id_i;
      end else if (w_beat_hs) begin
        r_count     <= r_count + 8'd1;
        r_beat_addr <= w_addr_next;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NB_PORTS; k++) begin
      trans_add_o[k] = 32'(r_beat_addr) + 32'(4 * k);
      trans_id_o[k]  = PER_ID_WIDTH'(r_id);
    end
  end

  axi2mem_id_fifo #(
    .DATA_WIDTH (FIFO_W),
    .DEPTH      (OUTSTANDING)
  ) u_id_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_valid_i (w_ar_hs),
    .push_ready_o (w_fifo_push_ready),
    .push_data_i  ({ar_id_i, ar_user_i, w_err}),
    .pop_valid_o  (w_fifo_pop_valid),
    .pop_ready_i  (w_fifo_pop_ready),
    .pop_data_o   (w_fifo_pop_data),
    .full_o       (w_fifo_full),
    .empty_o      (w_fifo_empty)
  );

  // Response path is pure wiring: the FIFO head only qualifies and tags the memory data.
  assign {w_head_id, w_head_user, w_head_err} = w_fifo_pop_data;
  assign r_valid_o        = data_valid_i && !w_fifo_empty;
  assign data_ready_o     = r_ready_i && !w_fifo_empty;
  assign r_data_o         = data_dat_i;
  assign r_last_o         = data_last_i;
  assign w_fifo_pop_ready = r_valid_o && r_ready_i && data_last_i;
  assign r_id_o           = w_fifo_empty ? '0 : w_head_id;
  assign r_user_o         = w_fifo_empty ? '0 : w_head_user;
  assign r_resp_o         = (!w_fifo_empty && w_head_err) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: doc/axi2mem_rd_ctrl.md
# axi2mem_rd_ctrl

Parametrised AXI4 read-channel controller that turns AR bursts into per-port memory requests and returns the data on R. It sits between the AXI slave port and the `NB_PORTS` 32-bit memory ports of axi2mem.

Compared with the fixed 64-bit, single-outstanding read channel it replaces, it adds:
- data width generalised to any multiple of 32 bits;
- FIXED/INCR/WRAP burst address generation;
- a configurable number of outstanding transactions;
- a correct valid/ready handshake on every interface.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 32, AR address width
- AXI_DATA_WIDTH, 64, R data width; multiple of 32, at most 1024
- AXI_ID_WIDTH, 3, AXI ID width
- AXI_USER_WIDTH, 6, AXI user width
- PER_ID_WIDTH, 6, memory-side ID width; at least AXI_ID_WIDTH
- OUTSTANDING, 4, ID FIFO depth; power of two, at least 2
- Derived (not overridable): NB_PORTS = AXI_DATA_WIDTH/32; BEAT_BYTES = AXI_DATA_WIDTH/8

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- ar_valid_i, ar_ready_o  in/out  1  AR handshake
- ar_addr_i  in  AXI_ADDR_WIDTH  byte address
- ar_len_i  in  8  beats minus 1
- ar_size_i  in  3  ignored; every beat is full width
- ar_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP
- ar_id_i  in  AXI_ID_WIDTH  transaction ID
- ar_user_i  in  AXI_USER_WIDTH  user field
- r_valid_o, r_ready_i  out/in  1  R handshake
- r_data_o  out  AXI_DATA_WIDTH  read data
- r_resp_o  out  2  read response
- r_last_o  out  1  last beat
- r_id_o  out  AXI_ID_WIDTH  response ID
- r_user_o  out  AXI_USER_WIDTH  response user field
- trans_req_o  out  NB_PORTS  per-port request
- trans_gnt_i  in  NB_PORTS  per-port grant
- trans_add_o  out  NB_PORTS x 32  per-port word address
- trans_id_o  out  NB_PORTS x PER_ID_WIDTH  zero-extended AXI ID
- trans_last_o  out  NB_PORTS  last beat of burst
- data_dat_i  in  AXI_DATA_WIDTH  returned memory data
- data_valid_i, data_ready_o  in/out  1  data handshake
- data_last_i  in  1  last beat of returned data

## Operation
- FSM states are IDLE and BURST.
- IDLE:
  - ar_ready_o = !fifo_full.
  - On AR handshake: capture addr (aligned down to BEAT_BYTES), len, burst and id; clear the 8-bit beat counter; push {id, user, err} into the ID FIFO; go to BURST.
- BURST:
  - All NB_PORTS trans_req_o are asserted together and held until the cycle in which all trans_gnt_i are 1 (a beat handshake).
  - Port k address = beat_addr + 4*k.
  - trans_last_o = (count == len) on all ports.
  - On each beat handshake: count += 1 and beat_addr advances.
  - On the handshake of the last beat: go to IDLE.
  - ar_ready_o = 0 in this state.
- Beat address advance:
  - FIXED: unchanged.
  - INCR: + BEAT_BYTES, wrapping modulo 2^AXI_ADDR_WIDTH.
  - WRAP: + BEAT_BYTES within a container of (len+1)*BEAT_BYTES, aligned to its own size. Low bits wrap; bits above the container are held.
- err is set when:
  - burst == 11, or
  - burst is WRAP with len not in {1, 3, 7, 15}.
- An err burst is still issued as INCR. Every one of its beats returns r_resp_o = 10 (SLVERR); otherwise r_resp_o = 00.
- Response path:
  - r_valid_o = data_valid_i & !fifo_empty.
  - data_ready_o = r_ready_i & !fifo_empty.
  - r_data_o = data_dat_i and r_last_o = data_last_i.
  - r_id_o, r_user_o and the err-derived r_resp_o come from the FIFO head.
  - The FIFO pops on an R handshake with r_last_o = 1.
- A FIFO push and pop in the same cycle are both allowed. Occupancy is unchanged; a push is allowed when full only if a pop occurs that cycle.

## Timing
- AR handshake to first trans_req_o: 1 cycle.
- Full-grant throughput: 1 beat per cycle. A burst of len+1 beats occupies BURST for len+1 cycles.
- Back-to-back bursts: the next ar_ready_o rises in the cycle after the last-beat handshake.
- data to R is combinational: zero latency, no storage.
- Reset values:
  - ar_ready_o = 0 while rst_ni is low.
  - trans_req_o, trans_last_o, r_valid_o, data_ready_o = 0.
  - r_resp_o and the FIFO are empty/0; FSM is in IDLE.
- Reset asserted mid-burst: requests drop immediately, the FIFO empties, and the in-flight burst is discarded.
- With OUTSTANDING bursts un-retired, ar_ready_o stays 0 until a last-beat R handshake.

## Structure
- Package axi2mem_pkg holds:
  - burst encodings BURST_FIXED/INCR/WRAP;
  - resp encodings RESP_OKAY/RESP_SLVERR;
  - the state typedef.
- Sub-module axi2mem_id_fifo: parametrised DATA_WIDTH and DEPTH; valid/ready push and pop; full and empty flags; asynchronous reset. It stores {id, user, err}.

## Test plan
- Single INCR burst: len=0 at 0x1004, 64-bit → one beat; ports request 0x1000 and 0x1004 with last=1; R returns id with last=1 and resp 00.
- WRAP burst: len=3 at 0x1018, 64-bit → beat addresses 0x1018, 0x1000, 0x1008, 0x1010.
- FIXED burst: len=2 at 0x2000 with grants toggling every other cycle → address constant at 0x2000; req held through non-grant cycles; exactly 3 beats issued.
- Outstanding limit: OUTSTANDING=4 with R held off and 5 ARs offered → 4 accepted, ar_ready_o low for the 5th until the first last-beat R handshake; IDs return in order.
- Error burst: WRAP with len=2 → issued as INCR over 3 beats; all three R beats have resp=10.
- Reset mid-burst: rst_ni low during beat 2 of len=7 → trans_req_o low the same cycle; after release ar_ready_o=1 and r_valid_o=0.
